bus_slave_mem: RTL and testbench

Parametrised memory slave for the shared system bus; the next generation of the fixed 2K-word slave.
- Depth, data width and wait states are set per instance.
- Out-of-range accesses get an ERROR response.
- An abort during wait states gets a RETRY response.
- Sits behind the address decoder (SEL) on the same HADDR/HWDATA/HRDATA/HRESP/HREADY/MLOCK bus.

---
 rtl/bus_slave_pkg.sv | 24 ++
 rtl/slave_mem_array.sv | 39 +++
 rtl/bus_slave_mem.sv | 149 ++++++++++++++
 tb/tb_bus_slave_mem.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/bus_slave_pkg.sv
// Shared definitions for the bus memory slave: FSM states, HRESP codes, HADDR fields.
package bus_slave_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACTIVE = 3'd1,
    WAIT   = 3'd2,
    WRITE  = 3'd3,
    READ   = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [1:0] RESP_RETRY = 2'b10;

  localparam int unsigned TRANS_BIT = 15;
  localparam int unsigned WRITE_BIT = 12;

  // Index width needed to address 'depth' words (at least one bit).
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/slave_mem_array.sv
// Single-port DEPTH x DATA_W memory: synchronous write, registered read.
// The read register is reset to zero; the array contents are not.
module slave_mem_array
  import bus_slave_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned IDX_W  = idx_width(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Holds the last read word until the next read strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bus_slave_mem.sv
// Parametrised bus memory slave with wait states, range ERROR and abort RETRY.
// Optional write protection above WP_BASE is enabled by defining BUS_SLAVE_WRPROT_EN.
module bus_slave_mem
  import bus_slave_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned DEPTH       = 2048,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned WP_BASE     = DEPTH - 256
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              SEL,
  input  logic [15:0]       HADDR,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              MLOCK,
  output logic [DATA_W-1:0] HRDATA,
  output logic [1:0]        HRESP,
  output logic              HREADY
);

  localparam int unsigned IDX_W = idx_width(DEPTH);
`ifdef BUS_SLAVE_WRPROT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  state_e            r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic              r_oe;
  logic              r_hready;
  logic [1:0]        r_hresp;

  logic [ADDR_W-1:0] w_addr;
  logic              w_trans;
  logic              w_wr;
  logic              w_in_range;
  logic              w_wp_hit;
  logic              w_we;
  logic              w_re;
  logic              w_unused_haddr;

  assign w_addr         = HADDR[ADDR_W-1:0];
  assign w_trans        = HADDR[TRANS_BIT];
  assign w_wr           = HADDR[WRITE_BIT];
  assign w_in_range     = (32'(w_addr) < DEPTH);
  assign w_wp_hit       = WP_EN && (32'(r_addr) >= WP_BASE);
  assign w_we           = (r_state == WRITE) && !w_wp_hit;
  assign w_re           = (r_state == READ);
  assign w_unused_haddr = ^HADDR;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_oe     <= 1'b0;
      r_hready <= 1'b0;
      r_hresp  <= RESP_OKAY;
    end else begin
      case (r_state)
        IDLE: begin
          r_hresp  <= RESP_OKAY;
          r_oe     <= SEL;
          r_hready <= SEL;
          if (SEL) begin
            r_state <= ACTIVE;
          end
        end

        ACTIVE: begin
          r_hresp  <= RESP_OKAY;
          r_oe     <= 1'b1;
          r_hready <= 1'b1;
          if (!SEL) begin
            r_state  <= IDLE;
            r_oe     <= 1'b0;
            r_hready <= 1'b0;
          end else if (w_trans) begin
            if (!w_in_range) begin
              r_hresp <= RESP_ERROR;
            end else begin
              r_addr   <= w_addr;
              r_write  <= w_wr;
              r_hready <= 1'b0;
              if (WAIT_STATES != 0) begin
                r_cnt   <= 4'(WAIT_STATES);
                r_state <= WAIT;
              end else begin
                r_state <= w_wr ? WRITE : READ;
              end
            end
          end
        end

        WAIT: begin
          // A locked transfer ignores SEL and always runs to completion.
          if (!SEL && !MLOCK) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_hready <= 1'b1;
            r_hresp  <= RESP_RETRY;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state <= r_write ? WRITE : READ;
            end
          end
        end

        WRITE, READ: begin
          r_hready <= 1'b1;
          r_hresp  <= ((r_state == WRITE) && w_wp_hit) ? RESP_ERROR : RESP_OKAY;
          r_state  <= SEL ? ACTIVE : IDLE;
        end

        default: begin
          r_state  <= IDLE;
          r_oe     <= 1'b0;
          r_hready <= 1'b0;
          r_hresp  <= RESP_OKAY;
        end
      endcase
    end
  end

  slave_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (r_addr[IDX_W-1:0]),
    .i_wdata (HWDATA),
    .o_rdata (HRDATA)
  );

  assign HRESP  = r_hresp;
  assign HREADY = r_oe ? r_hready : 1'bz;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Directed bench for bus_slave_mem: three instances (A: DEPTH=1000 WS=0, B: WS=3, C: WS=4).
module tb_bus_slave_mem;

  logic        clk;
  logic        rst_n;
  logic        sel    [3];
  logic [15:0] haddr  [3];
  logic [31:0] hwdata [3];
  logic        mlock  [3];
  logic [31:0] hrdata [3];
  logic [1:0]  hresp  [3];
  wire         hr0, hr1, hr2;
  wire  [2:0]  rdy_v;

  int n_checks = 0;
  int n_pass   = 0;

  assign rdy_v = {hr2, hr1, hr0};

  bus_slave_mem #(.DEPTH(1000), .WAIT_STATES(0), .WP_BASE(744)) u_a (
    .CLK(clk), .RST_N(rst_n), .SEL(sel[0]), .HADDR(haddr[0]), .HWDATA(hwdata[0]),
    .MLOCK(mlock[0]), .HRDATA(hrdata[0]), .HRESP(hresp[0]), .HREADY(hr0));

  bus_slave_mem #(.WAIT_STATES(3)) u_b (
    .CLK(clk), .RST_N(rst_n), .SEL(sel[1]), .HADDR(haddr[1]), .HWDATA(hwdata[1]),
    .MLOCK(mlock[1]), .HRDATA(hrdata[1]), .HRESP(hresp[1]), .HREADY(hr1));

  bus_slave_mem #(.WAIT_STATES(4)) u_c (
    .CLK(clk), .RST_N(rst_n), .SEL(sel[2]), .HADDR(haddr[2]), .HWDATA(hwdata[2]),
    .MLOCK(mlock[2]), .HRDATA(hrdata[2]), .HRESP(hresp[2]), .HREADY(hr2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One transfer from ACTIVE; counts HREADY-low samples from the address edge on.
  task automatic txn(input string tag, input int idx, input bit wr, input logic [10:0] a,
                     input logic [31:0] d, input bit drop, input bit lock,
                     input int exp_low, input logic [1:0] exp_resp,
                     input bit chk_rd, input logic [31:0] exp_rd);
    bit          done = 1'b0;
    int          low  = 0;
    logic [1:0]  resp = '0;
    logic [31:0] rd   = '0;
    @(negedge clk);
    haddr[idx]  = {1'b1, 2'b00, wr, 1'b0, a};
    hwdata[idx] = d;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      if (rdy_v[idx] === 1'b1) begin
        done = 1'b1;
        resp = hresp[idx];
        rd   = hrdata[idx];
      end else begin
        low++;
      end
      if (c == 0) begin
        haddr[idx] = '0;
        if (drop) begin
          sel[idx]   = 1'b0;
          mlock[idx] = lock;
        end
      end
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_low"}, low, exp_low);
    check({tag, "_resp"}, 32'(resp), 32'(exp_resp));
    if (chk_rd) check({tag, "_rdata"}, rd, exp_rd);
  endtask

  // After a transfer that ended with SEL low: one released cycle, then reselect.
  task automatic rejoin(input string tag, input int idx);
    @(posedge clk); #1;
    check({tag, "_idle_rdy"}, 32'(rdy_v[idx] === 1'b1), 32'd0);
    check({tag, "_idle_resp"}, 32'(hresp[idx]), 32'd0);
    @(negedge clk);
    sel[idx]   = 1'b1;
    mlock[idx] = 1'b0;
    @(posedge clk); #1;
    check({tag, "_act_rdy"}, 32'(rdy_v[idx] === 1'b1), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sel[i] = 1'b0; haddr[i] = '0; hwdata[i] = '0; mlock[i] = 1'b0;
    end
    #12;
    check("rst_rdy", 32'(rdy_v[0] === 1'b1), 32'd0);
    check("rst_resp", 32'(hresp[0]), 32'd0);
    check("rst_rdata", hrdata[0], 32'd0);
    check("rst_rdata_b", hrdata[1], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_rdy", 32'(rdy_v[0] === 1'b1), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) sel[i] = 1'b1;
    @(posedge clk); #1;
    check("act_rdy", 32'(rdy_v[0] === 1'b1), 32'd1);
    check("act_resp", 32'(hresp[0]), 32'd0);

    // Zero wait states
    txn("A_wr5",    0, 1'b1, 11'd5,    32'hDEADBEEF, 1'b0, 1'b0, 1, 2'b00, 1'b0, '0);
    txn("A_rd5",    0, 1'b0, 11'd5,    32'h0,        1'b0, 1'b0, 1, 2'b00, 1'b1, 32'hDEADBEEF);
    // Range boundary at DEPTH=1000
    txn("A_wr999",  0, 1'b1, 11'd999,  32'h99999999, 1'b0, 1'b0, 1, 2'b00, 1'b0, '0);
    txn("A_wr1000", 0, 1'b1, 11'd1000, 32'h01234567, 1'b0, 1'b0, 0, 2'b01, 1'b0, '0);
    txn("A_rd999",  0, 1'b0, 11'd999,  32'h0,        1'b0, 1'b0, 1, 2'b00, 1'b1, 32'h99999999);
    txn("A_rd1000", 0, 1'b0, 11'd1000, 32'h0,        1'b0, 1'b0, 0, 2'b01, 1'b1, 32'h99999999);
    txn("A_rd5b",   0, 1'b0, 11'd5,    32'h0,        1'b0, 1'b0, 1, 2'b00, 1'b1, 32'hDEADBEEF);

`ifdef BUS_SLAVE_WRPROT_EN
    txn("A_wp744",  0, 1'b1, 11'd744, 32'h0BADF00D, 1'b0, 1'b0, 1, 2'b01, 1'b0, '0);
    txn("A_rd744",  0, 1'b0, 11'd744, 32'h0,        1'b0, 1'b0, 1, 2'b00, 1'b0, '0);
    check("A_wp744_kept", 32'(hrdata[0] === 32'h0BADF00D), 32'd0);
    txn("A_wr743",  0, 1'b1, 11'd743, 32'h00000743, 1'b0, 1'b0, 1, 2'b00, 1'b0, '0);
    txn("A_rd743",  0, 1'b0, 11'd743, 32'h0,        1'b0, 1'b0, 1, 2'b00, 1'b1, 32'h00000743);
`else
    txn("A_wr744",  0, 1'b1, 11'd744, 32'h0BADF00D, 1'b0, 1'b0, 1, 2'b00, 1'b0, '0);
    txn("A_rd744",  0, 1'b0, 11'd744, 32'h0,        1'b0, 1'b0, 1, 2'b00, 1'b1, 32'h0BADF00D);
`endif

    // Three wait states: HREADY low for four cycles
    txn("B_wr7", 1, 1'b1, 11'd7, 32'h12345678, 1'b0, 1'b0, 4, 2'b00, 1'b0, '0);
    txn("B_rd7", 1, 1'b0, 11'd7, 32'h0,        1'b0, 1'b0, 4, 2'b00, 1'b1, 32'h12345678);

    // Four wait states: abort without lock, then locked completion with SEL low
    txn("C_wr9",   2, 1'b1, 11'd9, 32'hAAAA5555, 1'b0, 1'b0, 5, 2'b00, 1'b0, '0);
    txn("C_abort", 2, 1'b1, 11'd9, 32'h11112222, 1'b1, 1'b0, 1, 2'b10, 1'b0, '0);
    rejoin("C_abort", 2);
    txn("C_rd9a",  2, 1'b0, 11'd9, 32'h0,        1'b0, 1'b0, 5, 2'b00, 1'b1, 32'hAAAA5555);
    txn("C_lock",  2, 1'b1, 11'd9, 32'h33334444, 1'b1, 1'b1, 5, 2'b00, 1'b0, '0);
    rejoin("C_lock", 2);
    txn("C_rd9b",  2, 1'b0, 11'd9, 32'h0,        1'b0, 1'b0, 5, 2'b00, 1'b1, 32'h33334444);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
